// File: rtl/tlc_pkg.sv
// Shared phase codes, lamp encodings and lamp decode helpers for the
// two-road phase scheduler.
package tlc_pkg;

    typedef enum logic [2:0] {
        PH_G1  = 3'd0,
        PH_Y1  = 3'd1,
        PH_AR1 = 3'd2,
        PH_G2  = 3'd3,
        PH_Y2  = 3'd4,
        PH_AR2 = 3'd5
    } phase_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    function automatic logic [2:0] lamp_road1(input phase_t ph);
        logic [2:0] lamp;
        lamp = LAMP_RED;
        case (ph)
            PH_G1:   lamp = LAMP_GREEN;
            PH_Y1:   lamp = LAMP_YELLOW;
            default: lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

    function automatic logic [2:0] lamp_road2(input phase_t ph);
        logic [2:0] lamp;
        lamp = LAMP_RED;
        case (ph)
            PH_G2:   lamp = LAMP_GREEN;
            PH_Y2:   lamp = LAMP_YELLOW;
            default: lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Per-phase cycle counter: cleared on the edge that enters a new phase,
// saturating at T_MAX_GREEN-1, with threshold flags for the scheduler.
module tlc_phase_timer #(
    parameter int T_MIN_GREEN = 5,
    parameter int T_MAX_GREEN = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 1,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic min_done,
    output logic max_done,
    output logic yel_done,
    output logic ar_done
);

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(T_ALL_RED - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign min_done = (cnt_q >= MIN_LAST);
    assign max_done = (cnt_q >= MAX_LAST);
    assign yel_done = (cnt_q == YEL_LAST);
    assign ar_done  = (cnt_q == AR_LAST);

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-driven two-road phase scheduler (G1-Y1-AR1-G2-Y2-AR2 ring).
// Optional emergency preemption is compiled in with TLC_PREEMPT_EN.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int T_MIN_GREEN = 5,
    parameter int T_MAX_GREEN = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 1,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       req_1,
    input  logic       req_2,
    input  logic       preempt,
    input  logic       preempt_sel,
    output logic [2:0] out_1,
    output logic [2:0] out_2,
    output logic [2:0] phase,
    output logic       phase_chg
);

    phase_t phase_q;
    phase_t phase_d;
    logic   dem_1_q;
    logic   dem_1_d;
    logic   dem_2_q;
    logic   dem_2_d;
    logic   phase_chg_q;
    logic   phase_chg_d;
    logic   min_done;
    logic   max_done;
    logic   yel_done;
    logic   ar_done;

    tlc_phase_timer #(
        .T_MIN_GREEN (T_MIN_GREEN),
        .T_MAX_GREEN (T_MAX_GREEN),
        .T_YELLOW    (T_YELLOW),
        .T_ALL_RED   (T_ALL_RED),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rs),
        .clr      (phase_chg_d),
        .min_done (min_done),
        .max_done (max_done),
        .yel_done (yel_done),
        .ar_done  (ar_done)
    );

`ifndef TLC_PREEMPT_EN
    logic unused_preempt;
    assign unused_preempt = preempt ^ preempt_sel;
`endif

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_G1: begin
                // Gap-out needs an empty own road; max-out only needs opposing demand.
                if ((min_done && dem_2_q && !req_1) || (max_done && dem_2_q)) begin
                    phase_d = PH_Y1;
                end
`ifdef TLC_PREEMPT_EN
                if (preempt) begin
                    phase_d = preempt_sel ? PH_Y1 : PH_G1;
                end
`endif
            end
            PH_Y1:  if (yel_done) phase_d = PH_AR1;
            PH_AR1: if (ar_done)  phase_d = PH_G2;
            PH_G2: begin
                if ((min_done && dem_1_q && !req_2) || (max_done && dem_1_q)) begin
                    phase_d = PH_Y2;
                end
`ifdef TLC_PREEMPT_EN
                if (preempt) begin
                    phase_d = preempt_sel ? PH_G2 : PH_Y2;
                end
`endif
            end
            PH_Y2:  if (yel_done) phase_d = PH_AR2;
            PH_AR2: if (ar_done)  phase_d = PH_G1;
            default: phase_d = PH_AR2;
        endcase
    end

    always_comb begin
        phase_chg_d = (phase_d != phase_q);
        // A fresh request beats the clear on green entry.
        dem_1_d = req_1 | (dem_1_q & ~(phase_chg_d && (phase_d == PH_G1)));
        dem_2_d = req_2 | (dem_2_q & ~(phase_chg_d && (phase_d == PH_G2)));
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            phase_q     <= PH_AR2;
            dem_1_q     <= 1'b0;
            dem_2_q     <= 1'b0;
            phase_chg_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            dem_1_q     <= dem_1_d;
            dem_2_q     <= dem_2_d;
            phase_chg_q <= phase_chg_d;
        end
    end

    assign out_1     = lamp_road1(phase_q);
    assign out_2     = lamp_road2(phase_q);
    assign phase     = phase_q;
    assign phase_chg = phase_chg_q;

endmodule
